// File: rtl/machine_control.sv
// Machine-mode trap/return/WFI sequencer driving the CSR file strobes, PC mux select, flush and stall.
// Registered state, combinational outputs; RESET forces the RESET state and its outputs immediately.
module machine_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ILLEGAL_INSTR,
  input  logic       MISALIGNED_INSTR,
  input  logic       MISALIGNED_LOAD,
  input  logic       MISALIGNED_STORE,
  input  logic       ECALL,
  input  logic       EBREAK,
  input  logic       MRET,
  input  logic       WFI,
  input  logic       MIE,
  input  logic       MEIE,
  input  logic       MTIE,
  input  logic       MSIE,
  input  logic       MEIP,
  input  logic       MTIP,
  input  logic       MSIP,
  output logic       I_OR_E,
  output logic       SET_CAUSE,
  output logic [3:0] CAUSE_IN,
  output logic       SET_EPC,
  output logic       INSTRET_INC,
  output logic       MIE_CLEAR,
  output logic       MIE_SET,
  output logic [1:0] PC_SRC,
  output logic       FLUSH,
  output logic       STALL
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_OPERATING,
    ST_TRAP_TAKEN,
    ST_TRAP_RETURN,
    ST_WAIT
  } state_t;

  state_t state, next_state;

  logic       exc, wake, irq;
  logic [3:0] trap_cause;
  logic       trap_is_irq;

  assign exc  = ILLEGAL_INSTR | MISALIGNED_INSTR | MISALIGNED_LOAD |
                MISALIGNED_STORE | ECALL | EBREAK;
  assign wake = (MEIP & MEIE) | (MSIP & MSIE) | (MTIP & MTIE);
  assign irq  = MIE & wake;

  // Exceptions always outrank interrupts; within each group the order is fixed.
  always_comb begin
    trap_cause  = 4'd0;
    trap_is_irq = 1'b0;
    if (MISALIGNED_INSTR)       trap_cause = 4'd0;
    else if (ILLEGAL_INSTR)     trap_cause = 4'd2;
    else if (ECALL)             trap_cause = 4'd11;
    else if (EBREAK)            trap_cause = 4'd3;
    else if (MISALIGNED_LOAD)   trap_cause = 4'd4;
    else if (MISALIGNED_STORE)  trap_cause = 4'd6;
    else begin
      trap_is_irq = 1'b1;
      if (MEIP & MEIE)          trap_cause = 4'd11;
      else if (MSIP & MSIE)     trap_cause = 4'd3;
      else                      trap_cause = 4'd7;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_RESET;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    I_OR_E      = 1'b0;
    SET_CAUSE   = 1'b0;
    CAUSE_IN    = 4'd0;
    SET_EPC     = 1'b0;
    INSTRET_INC = 1'b0;
    MIE_CLEAR   = 1'b0;
    MIE_SET     = 1'b0;
    PC_SRC      = 2'b11;
    FLUSH       = 1'b0;
    STALL       = 1'b0;
    case (state)
      ST_RESET: begin
        PC_SRC     = 2'b00;
        FLUSH      = 1'b1;
        next_state = ST_OPERATING;
      end
      ST_OPERATING: begin
        if (exc | irq) begin
          SET_CAUSE  = 1'b1;
          SET_EPC    = 1'b1;
          MIE_CLEAR  = 1'b1;
          CAUSE_IN   = trap_cause;
          I_OR_E     = trap_is_irq;
          next_state = ST_TRAP_TAKEN;
        end else if (MRET) begin
          MIE_SET     = 1'b1;
          INSTRET_INC = 1'b1;
          next_state  = ST_TRAP_RETURN;
        end else if (WFI && !wake) begin
          STALL      = 1'b1;
          next_state = ST_WAIT;
        end else begin
          INSTRET_INC = 1'b1;
        end
      end
      ST_TRAP_TAKEN: begin
        PC_SRC     = 2'b10;
        FLUSH      = 1'b1;
        next_state = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        PC_SRC     = 2'b01;
        FLUSH      = 1'b1;
        next_state = ST_OPERATING;
      end
      ST_WAIT: begin
        // Wake ignores MIE; a taken interrupt is picked up back in OPERATING.
        STALL = 1'b1;
        if (wake) begin
          INSTRET_INC = 1'b1;
          next_state  = ST_OPERATING;
        end
      end
      default: next_state = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_machine_control.sv
// Bench for machine_control: directed test-plan sequences plus random stimulus against a behavioural model.
module tb_machine_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ILLEGAL_INSTR = 0, MISALIGNED_INSTR = 0, MISALIGNED_LOAD = 0, MISALIGNED_STORE = 0;
  logic       ECALL = 0, EBREAK = 0, MRET = 0, WFI = 0;
  logic       MIE = 0, MEIE = 0, MTIE = 0, MSIE = 0, MEIP = 0, MTIP = 0, MSIP = 0;
  logic       I_OR_E, SET_CAUSE, SET_EPC, INSTRET_INC, MIE_CLEAR, MIE_SET, FLUSH, STALL;
  logic [3:0] CAUSE_IN;
  logic [1:0] PC_SRC;

  machine_control dut (
    .CLK(CLK), .RESET(RESET),
    .ILLEGAL_INSTR(ILLEGAL_INSTR), .MISALIGNED_INSTR(MISALIGNED_INSTR),
    .MISALIGNED_LOAD(MISALIGNED_LOAD), .MISALIGNED_STORE(MISALIGNED_STORE),
    .ECALL(ECALL), .EBREAK(EBREAK), .MRET(MRET), .WFI(WFI),
    .MIE(MIE), .MEIE(MEIE), .MTIE(MTIE), .MSIE(MSIE),
    .MEIP(MEIP), .MTIP(MTIP), .MSIP(MSIP),
    .I_OR_E(I_OR_E), .SET_CAUSE(SET_CAUSE), .CAUSE_IN(CAUSE_IN), .SET_EPC(SET_EPC),
    .INSTRET_INC(INSTRET_INC), .MIE_CLEAR(MIE_CLEAR), .MIE_SET(MIE_SET),
    .PC_SRC(PC_SRC), .FLUSH(FLUSH), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  // Stimulus vector bit positions; exception bits 0..5 are listed in priority order.
  localparam int B_MINSTR = 0, B_ILL = 1, B_ECALL = 2, B_EBRK = 3, B_MLOAD = 4, B_MSTORE = 5;
  localparam int B_MRET = 6, B_WFI = 7, B_MIE = 8;
  localparam int B_MEIE = 9, B_MSIE = 10, B_MTIE = 11, B_MEIP = 12, B_MSIP = 13, B_MTIP = 14;
  localparam int B_RST = 15;

  int exc_code [6] = '{0, 2, 11, 3, 4, 6};
  int irq_code [3] = '{11, 3, 7};

  int n_checks = 0;
  int n_pass   = 0;

  // Model: in_reset, pending redirect (PC_SRC value for the next cycle, 0 = none), waiting for wake.
  bit m_reset = 1'b1;
  int m_redirect = 0;
  bit m_waiting = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input logic [15:0] v);
    int e_ioe, e_sc, e_cause, e_epc, e_ret, e_clr, e_set, e_pc, e_flush, e_stall;
    int exc_idx, irq_idx;
    bit wake;
    @(posedge CLK);
    #1;
    MISALIGNED_INSTR = v[B_MINSTR]; ILLEGAL_INSTR = v[B_ILL]; ECALL = v[B_ECALL];
    EBREAK = v[B_EBRK]; MISALIGNED_LOAD = v[B_MLOAD]; MISALIGNED_STORE = v[B_MSTORE];
    MRET = v[B_MRET]; WFI = v[B_WFI]; MIE = v[B_MIE];
    MEIE = v[B_MEIE]; MSIE = v[B_MSIE]; MTIE = v[B_MTIE];
    MEIP = v[B_MEIP]; MSIP = v[B_MSIP]; MTIP = v[B_MTIP];
    RESET = v[B_RST];
    if (v[B_RST]) begin
      m_reset = 1'b1; m_redirect = 0; m_waiting = 1'b0;
    end
    #1;
    e_ioe = 0; e_sc = 0; e_cause = 0; e_epc = 0; e_ret = 0;
    e_clr = 0; e_set = 0; e_pc = 3; e_flush = 0; e_stall = 0;
    wake = 1'b0;
    irq_idx = -1;
    for (int k = 0; k < 3; k++)
      if (v[B_MEIP+k] && v[B_MEIE+k]) begin
        wake = 1'b1;
        if (irq_idx < 0) irq_idx = k;
      end
    exc_idx = -1;
    for (int i = 5; i >= 0; i--) if (v[i]) exc_idx = i;

    if (m_reset) begin
      e_pc = 0; e_flush = 1;
      m_reset = v[B_RST];
    end else if (m_redirect != 0) begin
      e_pc = m_redirect; e_flush = 1;
      m_redirect = 0;
    end else if (m_waiting) begin
      e_stall = 1;
      if (wake) begin e_ret = 1; m_waiting = 1'b0; end
    end else if (exc_idx >= 0 || (v[B_MIE] && wake)) begin
      e_sc = 1; e_epc = 1; e_clr = 1;
      if (exc_idx >= 0) e_cause = exc_code[exc_idx];
      else begin e_cause = irq_code[irq_idx]; e_ioe = 1; end
      m_redirect = 2;
    end else if (v[B_MRET]) begin
      e_set = 1; e_ret = 1; m_redirect = 1;
    end else if (v[B_WFI] && !wake) begin
      e_stall = 1; m_waiting = 1'b1;
    end else begin
      e_ret = 1;
    end

    check("i_or_e", I_OR_E, e_ioe);
    check("set_cause", SET_CAUSE, e_sc);
    check("cause_in", CAUSE_IN, e_cause);
    check("set_epc", SET_EPC, e_epc);
    check("instret_inc", INSTRET_INC, e_ret);
    check("mie_clear", MIE_CLEAR, e_clr);
    check("mie_set", MIE_SET, e_set);
    check("pc_src", PC_SRC, e_pc);
    check("flush", FLUSH, e_flush);
    check("stall", STALL, e_stall);
  endtask

  function automatic logic [15:0] bits(input int a, input int b = -1, input int c = -1,
                                       input int d = -1, input int e = -1, input int f = -1,
                                       input int g = -1);
    logic [15:0] r;
    int l [7];
    r = '0;
    l = '{a, b, c, d, e, f, g};
    foreach (l[i]) if (l[i] >= 0) r[l[i]] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [15:0] all_irq, rv;
    all_irq = bits(B_MIE, B_MEIE, B_MSIE, B_MTIE, B_MEIP, B_MSIP, B_MTIP);

    // Reset held for 3 cycles, then released.
    repeat (3) begin
      step(bits(B_RST));
      check("rst_pc", PC_SRC, 0);
      check("rst_flush", FLUSH, 1);
    end
    step('0);
    step('0);
    check("post_rst_pc", PC_SRC, 3);
    check("post_rst_ret", INSTRET_INC, 1);

    // Exception beats a simultaneous interrupt; ILLEGAL beats ECALL.
    step(bits(B_ILL, B_ECALL, B_MEIP, B_MEIE, B_MIE));
    check("exc_cause", CAUSE_IN, 2);
    check("exc_ioe", I_OR_E, 0);
    check("exc_ret", INSTRET_INC, 0);
    step('0);
    check("exc_pc", PC_SRC, 2);
    check("exc_flush", FLUSH, 1);

    // Interrupt priority.
    step(all_irq);
    check("mei_cause", CAUSE_IN, 11);
    check("mei_ioe", I_OR_E, 1);
    step('0);
    step(all_irq & ~bits(B_MEIE));
    check("msi_cause", CAUSE_IN, 3);
    step('0);
    step(bits(B_MIE, B_MTIE, B_MTIP));
    check("mti_cause", CAUSE_IN, 7);
    step('0);
    step(all_irq & ~bits(B_MIE));
    check("mie0_sc", SET_CAUSE, 0);
    check("mie0_ret", INSTRET_INC, 1);

    // MRET.
    step(bits(B_MRET));
    check("mret_set", MIE_SET, 1);
    check("mret_ret", INSTRET_INC, 1);
    step('0);
    check("mret_pc", PC_SRC, 1);
    step('0);
    check("mret_pc2", PC_SRC, 3);

    // WFI with a timer wake 5 cycles later.
    step(bits(B_WFI));
    check("wfi_stall", STALL, 1);
    repeat (4) begin
      step('0);
      check("wait_stall", STALL, 1);
      check("wait_ret", INSTRET_INC, 0);
    end
    step(bits(B_MIE, B_MTIE, B_MTIP));
    check("wake_ret", INSTRET_INC, 1);
    check("wake_stall", STALL, 1);
    step(bits(B_MIE, B_MTIE, B_MTIP));
    check("wake_sc", SET_CAUSE, 1);
    check("wake_cause", CAUSE_IN, 7);
    step('0);

    // Async reset landing in the TRAP_TAKEN cycle.
    step(bits(B_EBRK));
    step(bits(B_RST));
    check("arst_pc", PC_SRC, 0);
    check("arst_flush", FLUSH, 1);
    check("arst_sc", SET_CAUSE, 0);
    step('0);
    step('0);
    check("arst_op_pc", PC_SRC, 3);

    // Random traffic: sparse exceptions, occasional MRET/WFI/reset.
    for (int n = 0; n < 3000; n++) begin
      rv = '0;
      for (int i = 0; i < 6; i++) rv[i] = ($urandom_range(0, 19) == 0);
      rv[B_MRET] = ($urandom_range(0, 7) == 0);
      rv[B_WFI]  = ($urandom_range(0, 4) == 0);
      rv[B_MIE]  = $urandom_range(0, 1);
      for (int k = 0; k < 3; k++) begin
        rv[B_MEIE+k] = $urandom_range(0, 1);
        rv[B_MEIP+k] = ($urandom_range(0, 3) == 0);
      end
      rv[B_RST] = ($urandom_range(0, 149) == 0);
      step(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/machine_control.md
# machine_control

Trap and privilege-flow controller for the Steel Core machine mode; the block on the other side of the CSR file's machine-control interface. It watches exception flags from the decoder and interrupt pending/enable bits from the CSR file, then issues the CSR file's strobes: SET_CAUSE, CAUSE_IN, I_OR_E, SET_EPC, MIE_CLEAR, MIE_SET and INSTRET_INC. It also drives the PC mux select, the pipeline flush and the stall used by WFI.

## Interface
- No parameters. Cause codes and PC_SRC encodings are fixed and listed under Operation.
- CLK  in  1  core clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- ILLEGAL_INSTR, MISALIGNED_INSTR, MISALIGNED_LOAD, MISALIGNED_STORE, ECALL, EBREAK, MRET, WFI  in  1 each  decoder flags for the instruction in the execute stage
- MIE  in  1  global interrupt enable (mstatus.MIE) from the CSR file
- MEIE, MTIE, MSIE  in  1 each  per-source enables from the CSR file
- MEIP, MTIP, MSIP  in  1 each  per-source pending bits from the CSR file
- I_OR_E  out  1  1 = interrupt, 0 = exception; valid with SET_CAUSE
- SET_CAUSE  out  1  load mcause from CAUSE_IN / I_OR_E
- CAUSE_IN  out  4  cause code
- SET_EPC  out  1  load mepc from PC_PLUS (PC_PLUS content is selected outside this block)
- INSTRET_INC  out  1  instruction retired this cycle
- MIE_CLEAR  out  1  clear mstatus.MIE (trap entry)
- MIE_SET  out  1  restore MIE from MPIE (MRET)
- PC_SRC  out  2  PC mux select: 00 boot, 01 EPC, 10 trap address, 11 next
- FLUSH  out  1  kill the instruction in the fetch/decode stages
- STALL  out  1  hold the PC and pipeline registers (WFI)

## Operation
- State machine with states RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN and WAIT. The state is registered; outputs are combinational from the state and the inputs.
- Exception `exc` = OR of the six exception flags.
- Per-source wake: `wake` = (MEIP&MEIE) | (MSIP&MSIE) | (MTIP&MTIE).
- Interrupt `irq` = MIE & wake.
- Exception priority and cause codes (I_OR_E = 0):
  - MISALIGNED_INSTR = 0
  - ILLEGAL_INSTR = 2
  - ECALL = 11
  - EBREAK = 3
  - MISALIGNED_LOAD = 4
  - MISALIGNED_STORE = 6
- Interrupt priority and cause codes (I_OR_E = 1): MEI = 11, then MSI = 3, then MTI = 7.
- Any exception beats any interrupt. A trap (exception or interrupt) beats MRET and WFI.
- **RESET:** PC_SRC = 00, FLUSH = 1, every other output 0. Goes to OPERATING unconditionally on the first edge after RESET deasserts.
- **OPERATING:** default PC_SRC = 11, FLUSH = 0, STALL = 0.
  - If `exc | irq`: assert SET_CAUSE, SET_EPC and MIE_CLEAR, drive CAUSE_IN and I_OR_E, INSTRET_INC = 0; next state TRAP_TAKEN.
  - Else if MRET: MIE_SET = 1, INSTRET_INC = 1; next state TRAP_RETURN.
  - Else if WFI and !wake: INSTRET_INC = 0, STALL = 1; next state WAIT.
  - Else: INSTRET_INC = 1; stay in OPERATING. This includes WFI when `wake` is already true, which behaves as a NOP.
- **TRAP_TAKEN:** PC_SRC = 10, FLUSH = 1, all strobes 0; next state OPERATING.
- **TRAP_RETURN:** PC_SRC = 01, FLUSH = 1, all strobes 0; next state OPERATING.
- **WAIT:** STALL = 1, PC_SRC = 11, FLUSH = 0.
  - If `wake`: INSTRET_INC = 1 (the WFI retires); next state OPERATING.
  - Otherwise stay in WAIT with INSTRET_INC = 0.
  - `wake` ignores MIE. Any taken interrupt is recognised in the following OPERATING cycle.
- Exceptions and interrupts are not sampled in TRAP_TAKEN, TRAP_RETURN or WAIT. A pending `irq` is serviced on the next OPERATING cycle, which lets a back-to-back interrupt be taken immediately after a return.
- When SET_CAUSE = 0, CAUSE_IN and I_OR_E are 0.

## Timing
- RESET is asynchronous: the state goes to RESET immediately, including mid-trap or in WAIT. Outputs take their RESET-state values in the same cycle.
- Trap entry takes 2 cycles.
  - Cycle N (OPERATING): strobes to the CSR file, which captures them at edge N+1.
  - Cycle N+1 (TRAP_TAKEN): PC_SRC = 10 and FLUSH = 1; the handler fetch starts at edge N+2.
- MRET takes 2 cycles: MIE_SET in cycle N, then PC_SRC = 01 and FLUSH in cycle N+1.
- WFI wake latency is 1 cycle: `wake` seen in WAIT at cycle N puts the FSM in OPERATING at N+1.
- Each strobe is asserted for at most one cycle per event.
- INSTRET_INC is never high in the same cycle as SET_CAUSE.

## Test plan
- **Reset:** RESET high for 3 cycles, then low.
  - Required: PC_SRC = 00, FLUSH = 1 while in RESET.
  - Required: OPERATING one cycle after release, with PC_SRC = 11 and INSTRET_INC = 1.
- **Exception priority:** ILLEGAL_INSTR = 1, ECALL = 1 and MEIP = MEIE = MIE = 1 in the same cycle.
  - Required: SET_CAUSE = 1, CAUSE_IN = 2, I_OR_E = 0, SET_EPC = 1, MIE_CLEAR = 1, INSTRET_INC = 0.
  - Required: next cycle PC_SRC = 10, FLUSH = 1.
- **Interrupt priority:** MIE = 1 with all three sources pending and enabled.
  - Required: CAUSE_IN = 11, I_OR_E = 1.
  - Repeat with MEIE = 0: CAUSE_IN = 3. Repeat with only MTIP/MTIE: CAUSE_IN = 7.
  - With MIE = 0: no SET_CAUSE, INSTRET_INC = 1.
- **MRET:** MRET = 1 in OPERATING.
  - Required: MIE_SET = 1, INSTRET_INC = 1.
  - Required: next cycle PC_SRC = 01, FLUSH = 1; the cycle after, PC_SRC = 11.
- **WFI:** WFI = 1 with no pending source, then MTIP = MTIE = 1 (MIE = 1) raised 5 cycles later.
  - Required: STALL = 1 and INSTRET_INC = 0 for 5 cycles, then INSTRET_INC = 1 with STALL = 1.
  - Required: next cycle OPERATING with SET_CAUSE = 1, CAUSE_IN = 7.
- **Async reset mid-trap:** RESET asserted during TRAP_TAKEN.
  - Required: in the same cycle PC_SRC = 00 and FLUSH = 1 with all strobes 0.
  - Required: OPERATING one cycle after release.
